// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if: bundles every non-clock signal of the instruction fetch stage.
//   Instruction-memory request:  imem_req_valid/imem_req_ready/imem_req_addr
//   Instruction-memory response: imem_resp_valid/imem_resp_data (in request order)
//   Decode side:                 inst_valid/inst/pc/pc_plus4, inst_ready
//   Execute side:                redirect/redirect_target, inst_misalign
// The master modport is the fetch unit; the slave modport is its environment
// (memory + decode + execute).
interface ifetch_unit_if #(
  parameter int XLEN = 64
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;
  logic            inst_valid;
  logic [31:0]     inst;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            inst_ready;
  logic            redirect;
  logic [XLEN-1:0] redirect_target;
  logic            inst_misalign;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output inst_valid, inst, pc, pc_plus4, inst_misalign,
    input  inst_ready, redirect, redirect_target
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  inst_valid, inst, pc, pc_plus4, inst_misalign,
    output inst_ready, redirect, redirect_target
  );
endinterface

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage feeding decode.
//   Owns the fetch PC, issues in-order requests to instruction memory, buffers
//   returned words with their PCs in a small prefetch FIFO and presents the head
//   {inst, pc} to decode. A redirect from execute flushes the FIFO and squashes
//   every response still in flight.
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous reset, active high
//   bus  - ifetch_unit_if.master (memory request/response, decode, redirect)
// Build option:
//   IFETCH_MISALIGN_TRAP_EN - when defined, a redirect target with bit 1 set
//   raises inst_misalign and halts fetch until the next aligned redirect or
//   reset. When undefined, target bits [1:0] are simply forced to zero.
module ifetch_unit #(
  parameter int              XLEN       = 64,
  parameter logic [XLEN-1:0] RESET_PC   = 64'h0000_0000_8000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input logic          clk,
  input logic          rst,
  ifetch_unit_if.master bus
);
  localparam int              PW       = $clog2(FIFO_DEPTH);
  localparam int              CW       = PW + 1;
  localparam logic [31:0]     NOP      = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(3'd4);
  localparam logic [PW-1:0]   PTR_ONE  = PW'(1'b1);
  localparam logic [CW:0]     DEPTH_W  = FIFO_DEPTH[CW:0];

  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic            halted_q, halted_d;
  logic            misalign_q, misalign_d;
  logic [31:0]     fifo_inst_q [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_pc_q   [FIFO_DEPTH];

  logic            inst_valid_s;
  logic            pop_s;
  logic            push_s;
  logic            drop_resp_s;
  logic            req_valid_s;
  logic            req_fire_s;
  logic [CW:0]     credit_used_s;
  logic [CW-1:0]   resp_dec_s;
  logic [CW-1:0]   fire_inc_s;
  logic [CW-1:0]   push_inc_s;
  logic [CW-1:0]   pop_dec_s;
  logic [XLEN-1:0] tgt_s;
  logic            tgt_mis_s;
  logic [XLEN-1:0] pc_s;

  // Redirect target shaping: which low bits are dropped and whether it traps
  always_comb begin
`ifdef IFETCH_MISALIGN_TRAP_EN
    tgt_s     = {bus.redirect_target[XLEN-1:1], 1'b0};
    tgt_mis_s = bus.redirect_target[1];
`else
    tgt_s     = {bus.redirect_target[XLEN-1:2], 2'b00};
    tgt_mis_s = 1'b0;
`endif
  end

  // Handshake decode and request credit
  always_comb begin
    inst_valid_s = !rst && (cnt_q != '0);
    pop_s        = inst_valid_s && bus.inst_ready;
    drop_resp_s  = bus.imem_resp_valid && ((drop_q != '0) || bus.redirect);
    push_s       = bus.imem_resp_valid && (drop_q == '0) && !bus.redirect;
    // A slot being popped this cycle is free for the response of a request
    // issued this cycle (it arrives at least one cycle later), which keeps a
    // two-entry FIFO streaming one instruction per cycle.
    credit_used_s = {1'b0, outst_q} + {1'b0, cnt_q} - CW'(pop_s);
    req_valid_s   = !rst && !bus.redirect && !halted_q && (credit_used_s < DEPTH_W);
    req_fire_s    = req_valid_s && bus.imem_req_ready;
    resp_dec_s    = CW'(bus.imem_resp_valid);
    fire_inc_s    = CW'(req_fire_s);
    push_inc_s    = CW'(push_s);
    pop_dec_s     = CW'(pop_s);
  end

  // Next-state logic; redirect overrides every other update
  always_comb begin
    fpc_d      = fpc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    cnt_d      = cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    halted_d   = halted_q;
    misalign_d = misalign_q;
    if (bus.redirect) begin
      fpc_d      = tgt_s;
      resp_pc_d  = tgt_s;
      cnt_d      = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      outst_d    = outst_q - resp_dec_s;
      // Responses already marked for dropping are still counted in outst_q,
      // so every request left in flight after this cycle is stale.
      drop_d     = outst_q - resp_dec_s;
      halted_d   = tgt_mis_s;
      misalign_d = tgt_mis_s;
    end else begin
      if (req_fire_s) begin
        fpc_d = fpc_q + PC_STEP;
      end else begin
        fpc_d = fpc_q;
      end
      outst_d = outst_q + fire_inc_s - resp_dec_s;
      if (drop_resp_s) begin
        drop_d = drop_q - resp_dec_s;
      end else begin
        drop_d = drop_q;
      end
      if (push_s) begin
        resp_pc_d = resp_pc_q + PC_STEP;
        wr_ptr_d  = wr_ptr_q + PTR_ONE;
      end else begin
        resp_pc_d = resp_pc_q;
        wr_ptr_d  = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      cnt_d = cnt_q + push_inc_s - pop_dec_s;
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q      <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      halted_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      fpc_q      <= fpc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      halted_q   <= halted_d;
      misalign_q <= misalign_d;
    end
  end

  // FIFO storage; contents are qualified by cnt_q so no reset is needed
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      fifo_inst_q[wr_ptr_q] <= bus.imem_resp_data;
      fifo_pc_q[wr_ptr_q]   <= resp_pc_q;
    end
  end

  // Output drive; an empty FIFO shows a NOP at the next expected PC
  always_comb begin
    if (rst) begin
      pc_s     = RESET_PC;
      bus.inst = NOP;
    end else if (inst_valid_s) begin
      pc_s     = fifo_pc_q[rd_ptr_q];
      bus.inst = fifo_inst_q[rd_ptr_q];
    end else begin
      pc_s     = resp_pc_q;
      bus.inst = NOP;
    end
    bus.pc             = pc_s;
    bus.pc_plus4       = pc_s + PC_STEP;
    bus.inst_valid     = inst_valid_s;
    bus.imem_req_valid = req_valid_s;
    bus.imem_req_addr  = fpc_q;
    bus.inst_misalign  = !rst && misalign_q;
  end

  ifetch_unit_chk #(.CW(CW), .FIFO_DEPTH(FIFO_DEPTH)) u_chk (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push_s),
    .resp_valid_i (bus.imem_resp_valid),
    .cnt_i        (cnt_q),
    .outst_i      (outst_q)
  );
endmodule

// ifetch_unit_chk: protocol and occupancy checks for ifetch_unit.
//   push_i/cnt_i       - a push must never target a full FIFO
//   resp_valid_i/outst_i - memory must not answer a request that was never made
module ifetch_unit_chk #(
  parameter int CW         = 2,
  parameter int FIFO_DEPTH = 2
) (
  input logic          clk,
  input logic          rst,
  input logic          push_i,
  input logic          resp_valid_i,
  input logic [CW-1:0] cnt_i,
  input logic [CW-1:0] outst_i
);
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    push_i |-> (cnt_i < FIFO_DEPTH[CW-1:0]));

  a_no_orphan_resp: assert property (@(posedge clk) disable iff (rst)
    resp_valid_i |-> (outst_i != '0));
endmodule
